// File: rtl/sseg_mux_slot.sv
// Four-digit common-anode seven-segment scanner on the slot bus.
// Double-buffered digit data, anti-ghost blanking and PWM dimming.
module sseg_mux_slot #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  localparam logic [4:0] A_DATA   = 5'd0;
  localparam logic [4:0] A_DPBL   = 5'd1;
  localparam logic [4:0] A_CTRL   = 5'd2;
  localparam logic [4:0] A_RAW    = 5'd3;
  localparam logic [4:0] A_STATUS = 5'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK   = CNT_W'(BLANK_CYCLES);

  logic [15:0] data_lv, data_sh;
  logic [7:0]  dpbl_lv, dpbl_sh;
  logic [31:0] raw_lv, raw_sh;
  logic        enable, raw_mode;
  logic [7:0]  bright;
  logic        pending;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [7:0]       pwm;

  logic wr_en;
  logic wr_shadowed;
  logic slot_end;
  logic commit;

  // Reads have no side effects, so the strobe is not needed.
  logic unused;
  assign unused = read;

  assign wr_en       = cs && write;
  assign wr_shadowed = wr_en && (reg_addr == A_DATA ||
                                 reg_addr == A_DPBL ||
                                 reg_addr == A_RAW);
  assign slot_end    = (cnt == CNT_MAX);
  assign commit      = slot_end && (idx == 2'd3) && pending;

  function automatic logic [6:0] hexdec(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h7F;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_lv  <= '0;
      dpbl_lv  <= '0;
      raw_lv   <= '0;
      enable   <= 1'b1;
      raw_mode <= 1'b0;
      bright   <= 8'hFF;
    end else if (wr_en) begin
      unique case (reg_addr)
        A_DATA: data_lv <= wr_data[15:0];
        A_DPBL: dpbl_lv <= wr_data[7:0];
        A_RAW:  raw_lv  <= wr_data;
        A_CTRL: begin
          enable   <= wr_data[0];
          raw_mode <= wr_data[1];
          bright   <= wr_data[15:8];
        end
        default: ;
      endcase
    end
  end

  // Commit samples live values before any same-cycle write lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_sh <= '0;
      dpbl_sh <= '0;
      raw_sh  <= '0;
      pending <= 1'b0;
    end else begin
      if (commit) begin
        data_sh <= data_lv;
        dpbl_sh <= dpbl_lv;
        raw_sh  <= raw_lv;
      end
      if (wr_shadowed)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
      pwm <= '0;
    end else begin
      pwm <= pwm + 8'd1;
      if (!enable) begin
        cnt <= '0;
        idx <= '0;
      end else if (slot_end) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  logic       digit_on;
  logic [3:0] an_nx;
  logic [7:0] sseg_nx;
  logic [3:0] nib;
  logic [7:0] raw_byte;

  assign nib      = data_sh[{idx, 2'b00} +: 4];
  assign raw_byte = raw_sh[{idx, 3'b000} +: 8];
  assign digit_on = enable && (cnt >= BLANK) &&
                    (pwm <= bright) && !dpbl_sh[4 + idx];

  always_comb begin
    an_nx   = 4'hF;
    sseg_nx = 8'hFF;
    if (digit_on) begin
      an_nx = ~(4'b0001 << idx);
      if (raw_mode)
        sseg_nx = ~raw_byte;
      else
        sseg_nx = {~dpbl_sh[idx], hexdec(nib)};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an   <= 4'hF;
      sseg <= 8'hFF;
    end else begin
      an   <= an_nx;
      sseg <= sseg_nx;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (reg_addr)
      A_DATA:   rd_data = {16'h0, data_lv};
      A_DPBL:   rd_data = {24'h0, dpbl_lv};
      A_CTRL:   rd_data = {16'h0, bright, 6'h0, raw_mode, enable};
      A_RAW:    rd_data = raw_lv;
      A_STATUS: rd_data = {29'h0, pending, idx};
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_sseg_mux_slot.sv
// Scoreboard bench for sseg_mux_slot: frame-position model predicts
// every output cycle; a negedge monitor pops and compares.
module tb_sseg_mux_slot;

  localparam int SD = 8;
  localparam int BL = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [3:0]  an;
  logic [7:0]  sseg;

  sseg_mux_slot #(
    .SCAN_DIV(SD),
    .BLANK_CYCLES(BL),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .read(read),
    .write(write),
    .reg_addr(reg_addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .an(an),
    .sseg(sseg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sseg;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: position within a 4-digit frame plus a free tick count.
  int          m_pos = 0;
  int          m_tick = 0;
  logic [15:0] m_data = '0, s_data = '0;
  logic [7:0]  m_dpbl = '0, s_dpbl = '0;
  logic [31:0] m_raw = '0, s_raw = '0;
  logic        m_en = 1'b1, m_rawm = 1'b0, m_pend = 1'b0;
  logic [7:0]  m_bright = 8'hFF;

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    case (a)
      5'd0: return {16'h0, m_data};
      5'd1: return {24'h0, m_dpbl};
      5'd2: return {16'h0, m_bright, 6'h0, m_rawm, m_en};
      5'd3: return m_raw;
      5'd4: return {29'h0, m_pend, 2'(m_pos / SD)};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int d, c;
    logic on;
    e = '{an: 4'hF, sseg: 8'hFF};
    if (reset) begin
      m_pos = 0; m_tick = 0;
      m_data = '0; s_data = '0;
      m_dpbl = '0; s_dpbl = '0;
      m_raw = '0;  s_raw = '0;
      m_en = 1'b1; m_rawm = 1'b0;
      m_bright = 8'hFF; m_pend = 1'b0;
    end else begin
      d = m_pos / SD;
      c = m_pos % SD;
      on = m_en && c >= BL && m_tick <= int'(m_bright) && !s_dpbl[4 + d];
      if (on) begin
        e.an = 4'hF & ~(4'b0001 << d);
        if (m_rawm) e.sseg = ~s_raw[d*8 +: 8];
        else e.sseg = {~s_dpbl[d], hex_tab[s_data[d*4 +: 4]]};
      end
      if (m_pos == FR - 1 && m_pend) begin
        s_data = m_data; s_dpbl = m_dpbl; s_raw = m_raw;
        m_pend = 1'b0;
      end
      m_pos = m_en ? (m_pos + 1) % FR : 0;
      m_tick = (m_tick + 1) % 256;
      if (cs && write) begin
        case (reg_addr)
          5'd0: begin m_data = wr_data[15:0]; m_pend = 1'b1; end
          5'd1: begin m_dpbl = wr_data[7:0];  m_pend = 1'b1; end
          5'd3: begin m_raw = wr_data;        m_pend = 1'b1; end
          5'd2: begin
            m_en = wr_data[0];
            m_rawm = wr_data[1];
            m_bright = wr_data[15:8];
          end
          default: ;
        endcase
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (an !== e.an || sseg !== e.sseg) begin
        miscompares++;
        $display("FAIL scan t=%0t an=%h sseg=%h expected an=%h sseg=%h",
                 $time, an, sseg, e.an, e.sseg);
      end
    end
  end

  // Called right after a negedge; drives, checks reads, advances a cycle.
  task automatic bus(input logic w, input logic r,
                     input logic [4:0] a, input logic [31:0] d);
    logic [31:0] x;
    cs = w | r; write = w; read = r; reg_addr = a; wr_data = d;
    #1;
    if (r) begin
      x = m_rd(a);
      vectors++;
      if (rd_data !== x) begin
        miscompares++;
        $display("FAIL read addr=%0d got=%h expected=%h", a, rd_data, x);
      end
    end
    @(negedge clk);
    cs = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    bus(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic wait_pos(input int p, input string tag);
    int k;
    k = 0;
    while (m_pos != p && k < 4 * FR) begin
      idle(1);
      k++;
    end
    if (m_pos != p) begin
      miscompares++;
      $display("FAIL %s timeout pos=%0d expected=%0d", tag, m_pos, p);
    end
  endtask

  task automatic reset_check(input string tag);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (an !== 4'hF || sseg !== 8'hFF) begin
      miscompares++;
      $display("FAIL %s an=%h sseg=%h expected an=f sseg=ff",
               tag, an, sseg);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int op;
    logic [31:0] v;
    logic [4:0]  a;
    repeat (2) @(negedge clk);
    reset_check("reset_hold");
    rd(5'd4);
    rd(5'd2);
    idle(3 * FR);
    wait_pos(SD + 3, "mid_frame");
    wr(5'd0, 32'h0000_1A3F);
    rd(5'd4);
    rd(5'd0);
    idle(2 * FR + 5);
    rd(5'd4);
    wr(5'd1, 32'h0000_0021);
    idle(2 * FR);
    wr(5'd2, 32'h0000_FF03);
    wr(5'd3, 32'h0000_0080);
    idle(2 * FR);
    wr(5'd2, 32'h0000_3F01);
    wr(5'd1, 32'h0000_0000);
    idle(600);
    wr(5'd2, 32'h0000_3F00);
    idle(1);
    rd(5'd4);
    idle(10);
    wr(5'd2, 32'h0000_FF01);
    wr(5'd0, 32'h0000_1111);
    wait_pos(FR - 1, "commit_sync");
    wr(5'd0, 32'h0000_2222);
    rd(5'd4);
    idle(FR);
    rd(5'd4);
    idle(2 * FR);
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                      : 5'($urandom_range(0, 4));
      v = $urandom;
      if (a == 5'd2) v[0] = ($urandom_range(0, 9) != 0);
      if (op < 3) wr(a, v);
      else if (op < 6) rd(a);
      else idle(1);
    end
    wr(5'd2, 32'h0000_FF01);
    wr(5'd1, 32'h0000_0000);
    idle(2 * FR);
    wait_pos(2 * SD + 4, "slot_mid");
    reset_check("reset_mid");
    rd(5'd4);
    rd(5'd0);
    idle(FR);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
